gcm_msg_sequencer: RTL and testbench

- Upstream feeder for the AES-GCM core.
- Accepts a message as a 32-bit word stream (AAD words, then payload words) over a valid/ready handshake.
- Packs words into 128-bit blocks and zero-pads the partial final block of each section.
- The GCM core consumes one block per cycle and cannot stall, so the whole message is buffered before launch. The block then drives start / authIn / finalAuth / blockIn / finalBlock exactly as the core's authInReady / blockReady / done timing requires.

---
 rtl/gcm_msg_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_gcm_msg_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_msg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : gcm_msg_sequencer
// Brief   : Buffers a whole AAD+payload message as 128-bit blocks, then feeds
//           it to the non-stalling AES-GCM core with its handshake timing.
// Revision: 1.0
// ============================================================================
module gcm_msg_sequencer #(
  parameter int DEPTH    = 32,
  parameter int MAX_AUTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_isAuth,
  input  logic         s_last,
  input  logic         s_end,
  input  logic         authInReady,
  input  logic         blockReady,
  input  logic         done,
  output logic         start,
  output logic         finalAuth,
  output logic         finalBlock,
  output logic [127:0] authIn,
  output logic [127:0] blockIn,
  output logic         busy,
  output logic         err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_AUTH_C = CW'(MAX_AUTH);

  localparam logic [2:0] S_FILL      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_AUTH      = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_RELEASE   = 3'd6;

  logic [2:0]    state, state_nx;
  logic [127:0]  mem [DEPTH];
  logic [CW-1:0] n_auth, n_data, rd;
  logic [1:0]    widx;
  logic [95:0]   pack;
  logic          started, aad_open, dropping, done_q;

  logic          accept, sect_auth, end_word, ovf, blk_end, wr_blk;
  logic [CW-1:0] total, last;
  logic [127:0]  block;

  assign accept    = s_valid & (state == S_FILL);
  // Until the first word arrives the section comes from s_isAuth; after that
  // it is purely positional (AAD stays open until its s_last).
  assign sect_auth = started ? aad_open : s_isAuth;
  assign end_word  = s_last & (~sect_auth | s_end);
  assign total     = n_auth + n_data;
  assign last      = total - CW'(1);
  assign ovf       = ~dropping & (widx == 2'd0) &
                     ((sect_auth & (n_auth == MAX_AUTH_C)) | (total == DEPTH_C));
  assign blk_end   = s_last | (widx == 2'd3);
  assign wr_blk    = accept & ~dropping & ~ovf & blk_end;

  always_comb begin
    block = '0;
    case (widx)
      2'd0:    block = {s_data, 96'b0};
      2'd1:    block = {pack[95:64], s_data, 64'b0};
      2'd2:    block = {pack[95:32], s_data, 32'b0};
      default: block = {pack, s_data};
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_blk) mem[total[AW-1:0]] <= block;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_auth   <= '0;
      n_data   <= '0;
      rd       <= '0;
      widx     <= '0;
      pack     <= '0;
      started  <= 1'b0;
      aad_open <= 1'b0;
      dropping <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done;
      if (accept) begin
        if (dropping | ovf) begin
          // Keep tracking sections so the true end word can be found.
          n_auth   <= '0;
          n_data   <= '0;
          widx     <= '0;
          started  <= ~end_word;
          aad_open <= sect_auth & ~s_last & ~end_word;
          dropping <= ~end_word;
        end else begin
          case (widx)
            2'd0:    pack[95:64] <= s_data;
            2'd1:    pack[63:32] <= s_data;
            2'd2:    pack[31:0]  <= s_data;
            default: ;
          endcase
          widx     <= blk_end ? 2'd0 : widx + 2'd1;
          started  <= ~end_word;
          aad_open <= sect_auth & ~s_last;
          if (blk_end) begin
            if (sect_auth) n_auth <= n_auth + CW'(1);
            else           n_data <= n_data + CW'(1);
          end
        end
      end
      case (state)
        S_LAUNCH:  rd <= '0;
        S_AUTH:    if (authInReady) rd <= rd + CW'(1);
        S_DATA:    if (blockReady)  rd <= rd + CW'(1);
        S_RELEASE: begin
          rd     <= '0;
          n_auth <= '0;
          n_data <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FILL:      if (accept & ~dropping & ~ovf & end_word) state_nx = S_LAUNCH;
      S_LAUNCH:    state_nx = (n_auth == '0) ? S_WAIT_DATA : S_AUTH;
      S_AUTH:      if (authInReady && rd == n_auth - CW'(1)) state_nx = S_WAIT_DATA;
      S_WAIT_DATA: begin
        // With no payload the core only signals leaving its wait via done.
        if (n_data != '0) begin
          if (blockReady) state_nx = S_DATA;
        end else if (done & ~done_q) begin
          state_nx = S_WAIT_DONE;
        end
      end
      S_DATA:      if (blockReady && rd == last) state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (done) state_nx = S_RELEASE;
      S_RELEASE:   state_nx = S_FILL;
      default:     state_nx = S_FILL;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    finalAuth  = 1'b0;
    finalBlock = 1'b0;
    authIn     = '0;
    blockIn    = '0;
    case (state)
      S_LAUNCH: begin
        start     = 1'b1;
        finalAuth = (n_auth == '0);
      end
      S_AUTH: begin
        start     = 1'b1;
        authIn    = mem[rd[AW-1:0]];
        finalAuth = (rd == n_auth - CW'(1));
      end
      S_WAIT_DATA: begin
        start      = 1'b1;
        finalBlock = (n_data == '0);
      end
      S_DATA: begin
        start      = 1'b1;
        blockIn    = mem[rd[AW-1:0]];
        finalBlock = (rd == last);
      end
      S_WAIT_DONE: start = 1'b1;
      default: ;
    endcase
  end

  assign s_ready = (state == S_FILL);
  assign busy    = (state != S_FILL);
  assign err     = accept & ovf;

endmodule
`default_nettype wire

// File: tb/tb_gcm_msg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_gcm_msg_sequencer
// Brief   : Message-level bench for gcm_msg_sequencer with a small GCM core model.
// Revision: 1.0
// ============================================================================
module tb_gcm_msg_sequencer;

  localparam int DEPTH    = 32;
  localparam int MAX_AUTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_data;
  logic         s_valid, s_ready, s_isAuth, s_last, s_end;
  logic         authInReady, blockReady, done;
  logic         start, finalAuth, finalBlock, busy, err;
  logic [127:0] authIn, blockIn;

  always #5 clk = ~clk;

  gcm_msg_sequencer #(.DEPTH(DEPTH), .MAX_AUTH(MAX_AUTH)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_isAuth(s_isAuth), .s_last(s_last), .s_end(s_end),
    .authInReady(authInReady), .blockReady(blockReady), .done(done),
    .start(start), .finalAuth(finalAuth), .finalBlock(finalBlock),
    .authIn(authIn), .blockIn(blockIn), .busy(busy), .err(err)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: message words, padded blocks, overflow position
  function automatic logic [31:0] word_of(input logic [31:0] base, input int i);
    return base + 32'(i) * 32'h9E37_79B1;
  endfunction

  function automatic logic [127:0] exp_blk(input logic [31:0] base, input int off,
                                           input int cnt, input int j);
    logic [127:0] b = '0;
    for (int w = 0; w < 4; w++)
      if (4 * j + w < cnt) b[127 - 32 * w -: 32] = word_of(base, off + 4 * j + w);
    return b;
  endfunction

  function automatic int exp_err_pos(input int na, input int np);
    int nab = (na + 3) / 4;
    int npb = (np + 3) / 4;
    for (int b = 0; b < nab + npb; b++)
      if ((b < nab && b >= MAX_AUTH) || b >= DEPTH)
        return (b < nab) ? 4 * b : na + 4 * (b - nab);
    return -1;
  endfunction

  task automatic send_msg(input int na, input int np, input logic [31:0] base,
                          input int gap, input int epos, input string tag);
    int total = na + np;
    int i = 0, cyc = 0, first_err = -1, nerr = 0;
    bit busy_seen = 1'b0;
    while (i < total && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      s_valid  = ($urandom_range(0, 99) >= gap);
      s_data   = word_of(base, i);
      s_isAuth = (i == 0) ? (na > 0) : ((i < na) ? 1'b1 : 1'($urandom_range(0, 1)));
      s_last   = (i == na - 1) || (i == total - 1);
      s_end    = (i == total - 1) ? 1'b1 : (s_last ? 1'b0 : 1'($urandom_range(0, 1)));
      #1;
      busy_seen |= busy;
      if (s_valid && s_ready) begin
        if (err) begin
          nerr++;
          if (first_err < 0) first_err = i;
        end
        i++;
      end else if (err) begin
        nerr++;
      end
    end
    if (i < total) tmo({tag, " send"});
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_end   = 1'b0;
    chk({tag, " err word index"}, first_err, epos);
    chk({tag, " err pulse count"}, nerr, (epos >= 0) ? 1 : 0);
    if (epos < 0) chk({tag, " start at T+1"}, {start, busy, s_ready}, 3'b110);
    else          chk({tag, " no launch after drop"}, {busy_seen, start, busy}, 3'b000);
  endtask

  task automatic core_run(input int na, input int np, input logic [31:0] base,
                          input int exp_nab, input int exp_npb, input bit rnd,
                          input string tag);
    int j = 0, k = 0, cyc = 0;
    bit r, fin, empty_pay;
    while (start !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (start !== 1'b1) begin
      tmo({tag, " launch"});
      return;
    end
    chk({tag, " launch finalAuth"}, finalAuth, exp_nab == 0);
    fin = finalAuth;
    cyc = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      authInReady = r;
      if (r) begin
        chk({tag, " authIn"}, authIn, exp_blk(base, 0, na, j));
        fin = finalAuth;
        j++;
      end
    end
    if (!fin) tmo({tag, " aad phase"});
    @(negedge clk);
    authInReady = 1'b0;
    chk({tag, " aad block count"}, j, exp_nab);
    empty_pay = finalBlock;
    chk({tag, " wait finalBlock"}, finalBlock, exp_npb == 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk({tag, " wait held"}, {finalBlock, start, authIn, blockIn}, {empty_pay, 1'b1, 256'b0});
    if (!empty_pay) begin
      blockReady = 1'b1;
      fin = 1'b0;
      cyc = 0;
      while (!fin && cyc < 400) begin
        @(negedge clk);
        cyc++;
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        blockReady = r;
        if (r) begin
          chk({tag, " blockIn"}, blockIn, exp_blk(base, na, np, k));
          fin = finalBlock;
          k++;
        end
      end
      if (!fin) tmo({tag, " data phase"});
      @(negedge clk);
      blockReady = 1'b0;
    end
    chk({tag, " data block count"}, k, exp_npb);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    done = 1'b1;
    if (empty_pay) begin
      @(negedge clk);
      chk({tag, " start held to done"}, start, 1'b1);
    end
    @(negedge clk);
    chk({tag, " start drops after done"}, start, 1'b0);
    done = 1'b0;
    @(negedge clk);
    chk({tag, " back to fill"}, {s_ready, busy}, 2'b10);
  endtask

  task automatic run_msg(input int na, input int np, input int nab, input int npb,
                         input int epos, input int gap, input bit rnd, input string tag);
    logic [31:0] base = $urandom;
    send_msg(na, np, base, gap, epos, tag);
    if (epos < 0) begin
      core_run(na, np, base, nab, npb, rnd, tag);
    end else begin
      repeat (3) @(negedge clk);
      chk({tag, " idle after drop"}, {start, busy, s_ready}, 3'b001);
    end
  endtask

  typedef struct {
    int na;
    int np;
    int nab;
    int npb;
    int epos;
  } vec_t;

  initial begin
    vec_t vecs[11];
    logic [31:0] b1, b2;
    vecs[0]  = '{2, 8, 1, 2, -1};
    vecs[1]  = '{0, 4, 0, 1, -1};
    vecs[2]  = '{4, 0, 1, 0, -1};
    vecs[3]  = '{68, 0, 0, 0, 64};
    vecs[4]  = '{3, 5, 1, 2, -1};
    vecs[5]  = '{64, 64, 16, 16, -1};
    vecs[6]  = '{8, 125, 0, 0, 128};
    vecs[7]  = '{70, 6, 0, 0, 64};
    vecs[8]  = '{1, 1, 1, 1, -1};
    vecs[9]  = '{0, 1, 0, 1, -1};
    vecs[10] = '{5, 0, 2, 0, -1};

    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_isAuth = 1'b0; s_last = 1'b0; s_end = 1'b0;
    authInReady = 1'b0; blockReady = 1'b0; done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {start, finalAuth, finalBlock, busy, err, s_ready, authIn, blockIn},
        {6'b000001, 256'b0});
    rst = 1'b0;

    foreach (vecs[v])
      run_msg(vecs[v].na, vecs[v].np, vecs[v].nab, vecs[v].npb, vecs[v].epos, 0, 1'b0, "vec");

    // Reset during DATA after the first of three payload blocks
    b1 = $urandom;
    send_msg(0, 12, b1, 0, -1, "rst msg");
    @(negedge clk);
    blockReady = 1'b1;
    @(negedge clk);
    chk("rst msg block0", blockIn, exp_blk(b1, 0, 12, 0));
    @(negedge clk);
    blockReady = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", {start, finalBlock, busy, s_ready, blockIn}, {4'b0001, 128'b0});
    @(negedge clk);
    rst = 1'b0;
    run_msg(2, 6, 1, 2, -1, 0, 1'b0, "after rst");

    // Back-to-back: second message stalls until the first releases
    b1 = $urandom;
    b2 = $urandom;
    send_msg(6, 9, b1, 0, -1, "b2b first");
    fork
      core_run(6, 9, b1, 2, 3, 1'b0, "b2b first");
      send_msg(3, 4, b2, 0, -1, "b2b second");
      begin
        @(negedge clk);
        #2;
        chk("b2b stalled", {s_valid, s_ready}, 2'b10);
      end
    join
    core_run(3, 4, b2, 1, 1, 1'b0, "b2b second");

    for (int n = 0; n < 24; n++) begin
      int na, np, e;
      bit big;
      big = ($urandom_range(0, 9) == 0);
      na  = big ? $urandom_range(0, 80) : $urandom_range(0, 20);
      np  = big ? $urandom_range(0, 110) : $urandom_range(0, 24);
      if (na == 0 && np == 0) np = 1;
      e = exp_err_pos(na, np);
      run_msg(na, np, (na + 3) / 4, (np + 3) / 4, e, 30, 1'b1, "rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
